// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem handshake, skid buffer, IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [5:0]  opcode
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] branchTarget;
  logic [31:0] bufInstr;
  logic [31:0] bufPc4;
  logic        branchGo;

  // A branch only counts when ID really holds it and is free to retire it this cycle.
  assign branchGo     = branch_taken && id_valid && !stall;
  assign pcPlus4      = pc + 32'd4;
  assign branchTarget = id_pc4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // Address comes straight from the PC register, so no input reaches it combinationally.
  assign imem_addr = pc;
  assign opcode    = id_instr[31:26];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic; a honoured branch overrides every other transition.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = REQ;
      REQ: begin
        if (branchGo)                             stateNext = REQ;
        else if (imem_ready && stall && id_valid) stateNext = HOLD;
        else                                      stateNext = REQ;
      end
      HOLD: begin
        if (branchGo)    stateNext = REQ;
        else if (!stall) stateNext = REQ;
        else             stateNext = HOLD;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request depends only on state: no fetching while idle or while the skid buffer is full.
  always_comb begin
    imem_req = (state == REQ);
  end

  // PC, IF/ID register and one-entry skid buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      id_instr <= 32'd0;
      id_pc4   <= 32'd0;
      id_valid <= 1'b0;
      bufInstr <= 32'd0;
      bufPc4   <= 32'd0;
    end else if (branchGo) begin
      // Redirect: the buffered word and any response this cycle are wrong-path, drop them.
      pc       <= branchTarget;
      id_valid <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (imem_ready) begin
            pc <= pcPlus4;
            if (!stall || !id_valid) begin
              id_instr <= imem_rdata;
              id_pc4   <= pcPlus4;
              id_valid <= 1'b1;
            end else begin
              bufInstr <= imem_rdata;
              bufPc4   <= pcPlus4;
            end
          end else if (!stall) begin
            id_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_instr <= bufInstr;
            id_pc4   <= bufPc4;
            id_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;

  localparam logic [31:0] PC_A = 32'h0000_0400;
  localparam logic [31:0] PC_B = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;

  logic        reqA, reqB, validA, validB;
  logic [31:0] addrA, addrB, instrA, instrB, pc4A, pc4B;
  logic [5:0]  opA, opB;

  int checks = 0;
  int errors = 0;
  bit randomData = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] bufInstr;
    logic [31:0] bufPc4;
    logic        valid;
    logic        warm;
    logic        hasBuf;
  } mdl_t;

  mdl_t mdlA, mdlB;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(PC_A)) u_dutA (
    .clk(clk), .rst_n(rst_n), .imem_req(reqA), .imem_addr(addrA),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_imm(branch_imm),
    .id_instr(instrA), .id_pc4(pc4A), .id_valid(validA), .opcode(opA)
  );

  fetch_stage #(.RESET_PC(PC_B)) u_dutB (
    .clk(clk), .rst_n(rst_n), .imem_req(reqB), .imem_addr(addrB),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_imm(branch_imm),
    .id_instr(instrB), .id_pc4(pc4B), .id_valid(validB), .opcode(opB)
  );

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One model step: the instruction stream seen at one clock edge.
  function automatic mdl_t modelStep(input mdl_t m, input logic [31:0] resetPc, input logic rstn,
                                     input logic rdy, input logic [31:0] rdata, input logic stl,
                                     input logic bt, input logic [15:0] imm);
    mdl_t n;
    logic [31:0] offset;
    n = m;
    offset = {{16{imm[15]}}, imm} * 32'd4;
    if (!rstn) begin
      n = '0;
      n.pc = resetPc;
    end else if (!m.warm) begin
      n.warm = 1'b1;
    end else if (bt && m.valid && !stl) begin
      n.pc = m.pc4 + offset;
      n.valid = 1'b0;
      n.hasBuf = 1'b0;
    end else if (m.hasBuf) begin
      if (!stl) begin
        n.instr = m.bufInstr;
        n.pc4 = m.bufPc4;
        n.valid = 1'b1;
        n.hasBuf = 1'b0;
      end
    end else if (rdy) begin
      n.pc = m.pc + 32'd4;
      if (!stl || !m.valid) begin
        n.instr = rdata;
        n.pc4 = m.pc + 32'd4;
        n.valid = 1'b1;
      end else begin
        n.bufInstr = rdata;
        n.bufPc4 = m.pc + 32'd4;
        n.hasBuf = 1'b1;
      end
    end else if (!stl) begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  task automatic compareAll();
    checkValue("reqA",   {31'd0, reqA},   {31'd0, mdlA.warm && !mdlA.hasBuf});
    checkValue("addrA",  addrA,           mdlA.pc);
    checkValue("instrA", instrA,          mdlA.instr);
    checkValue("pc4A",   pc4A,            mdlA.pc4);
    checkValue("validA", {31'd0, validA}, {31'd0, mdlA.valid});
    checkValue("opA",    {26'd0, opA},    {26'd0, mdlA.instr[31:26]});
    checkValue("reqB",   {31'd0, reqB},   {31'd0, mdlB.warm && !mdlB.hasBuf});
    checkValue("addrB",  addrB,           mdlB.pc);
    checkValue("instrB", instrB,          mdlB.instr);
    checkValue("pc4B",   pc4B,            mdlB.pc4);
    checkValue("validB", {31'd0, validB}, {31'd0, mdlB.valid});
    checkValue("opB",    {26'd0, opB},    {26'd0, mdlB.instr[31:26]});
  endtask

  // Drive one cycle at a negedge, advance the models at the edge, compare at the next negedge.
  task automatic cycle(input logic rstn, input logic rdy, input logic stl, input logic bt,
                       input logic [15:0] imm);
    rst_n = rstn;
    imem_ready = rdy;
    stall = stl;
    branch_taken = bt;
    branch_imm = imm;
    imem_rdata = randomData ? $urandom : addrA;
    @(posedge clk);
    mdlA = modelStep(mdlA, PC_A, rstn, rdy, imem_rdata, stl, bt, imm);
    mdlB = modelStep(mdlB, PC_B, rstn, rdy, imem_rdata, stl, bt, imm);
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    mdlA = '0;
    mdlB = '0;
    rst_n = 1'b0;
    imem_ready = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_imm = 16'd0;
    imem_rdata = 32'd0;
    @(negedge clk);

    // Reset held three cycles.
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    checkValue("rst_addrA", addrA, 32'h0000_0400);
    checkValue("rst_addrB", addrB, 32'hFFFF_FFFC);
    checkValue("rst_req", {31'd0, reqA}, 32'd0);
    checkValue("rst_op", {26'd0, opA}, 32'd0);

    // Release: one idle cycle, then request.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checkValue("first_req", {31'd0, reqA}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checkValue("stream0", instrA, 32'h0000_0400);
    checkValue("wrap_addrB", addrB, 32'h0000_0000);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checkValue("stream2", instrA, 32'h0000_0408);
    checkValue("stream2_pc4", pc4A, 32'h0000_040C);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checkValue("pre_br_pc4", pc4A, 32'h0000_0410);

    // Backward branch.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFC);
    checkValue("br_back_addr", addrA, 32'h0000_0400);
    checkValue("br_bubble", {31'd0, validA}, 32'd0);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checkValue("pre_br2_pc4", pc4A, 32'h0000_0410);

    // Forward branch.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0003);
    checkValue("br_fwd_addr", addrA, 32'h0000_041C);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checkValue("pre_stall", instrA, 32'h0000_0420);

    // Stall three cycles with a branch request that must be ignored.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0003);
    checkValue("hold_req", {31'd0, reqA}, 32'd0);
    checkValue("hold_addr", addrA, 32'h0000_0428);
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    checkValue("hold_instr", instrA, 32'h0000_0420);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checkValue("unhold0", instrA, 32'h0000_0424);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checkValue("unhold1", instrA, 32'h0000_0428);

    // Four wait states.
    repeat (4) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      checkValue("wait_addr", addrA, 32'h0000_042C);
      checkValue("wait_bubble", {31'd0, validA}, 32'd0);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    checkValue("after_wait", instrA, 32'h0000_042C);

    // Enter HOLD, then reset from it.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    checkValue("hold2_req", {31'd0, reqA}, 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    checkValue("rst_hold_addr", addrA, 32'h0000_0400);
    checkValue("rst_hold_instr", instrA, 32'd0);
    checkValue("rst_hold_pc4", pc4A, 32'd0);
    checkValue("rst_hold_valid", {31'd0, validA}, 32'd0);

    // Randomized traffic against the model.
    randomData = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15) - 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
